// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job scheduler: core operand width and the
// scheduler state encoding.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

endpackage

// File: rtl/gcd_operand_fifo.sv
// Small synchronous FIFO holding operand pairs until the scheduler issues them.
// A push while full is dropped even if a pop frees a slot in the same cycle.
module gcd_operand_fifo
    import gcd_pkg::*;
#(
    parameter int DATA_W = 2 * GCD_WIDTH,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == CNT_W'(0));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Wraps the GCD core: buffers operand pairs, issues them one at a time with the
// core's start/done protocol and presents each tagged result on a valid/ready port.
module gcd_job_scheduler
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_gcd,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_gcd,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    sched_state_e       state_q;
    sched_state_e       state_d;
    logic               done_q;
    logic [TAG_W-1:0]   tag_q;
    logic               core_start_q;
    logic [WIDTH-1:0]   core_a_q;
    logic [WIDTH-1:0]   core_b_q;
    logic               res_valid_q;
    logic [WIDTH-1:0]   res_gcd_q;
    logic [TAG_W-1:0]   res_tag_q;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [2*WIDTH-1:0] fifo_head_s;
    logic               pop_s;
    logic               capture_s;
    logic               done_rise_s;

    gcd_operand_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .data_i  ({in_a, in_b}),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Only the first done cycle of a job counts; the second one is drained.
    assign done_rise_s = core_done && !done_q;

    assign in_ready   = !fifo_full_s;
    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign res_valid  = res_valid_q;
    assign res_gcd    = res_gcd_q;
    assign res_tag    = res_tag_q;
    assign busy       = (state_q != ST_IDLE) || (fifo_count_s != CNT_W'(0)) || res_valid_q;

    // Scheduler state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !res_valid_q) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                if (done_rise_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DRAIN: begin
                if (!core_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state control strobes: pop/issue from IDLE, capture from BUSY
    always_comb begin
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE:  pop_s     = !fifo_empty_s && !res_valid_q;
            ST_BUSY:  capture_s = done_rise_s;
            ST_ISSUE: pop_s     = 1'b0;
            ST_DRAIN: capture_s = 1'b0;
            default: begin
                pop_s     = 1'b0;
                capture_s = 1'b0;
            end
        endcase
    end

    // Core-side registers: start pulse and operands loaded on the pop cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_start_q <= 1'b0;
            core_a_q     <= {WIDTH{1'b0}};
            core_b_q     <= {WIDTH{1'b0}};
            done_q       <= 1'b0;
        end else begin
            core_start_q <= pop_s;
            done_q       <= core_done;
            if (pop_s) begin
                core_a_q <= fifo_head_s[2*WIDTH-1:WIDTH];
                core_b_q <= fifo_head_s[WIDTH-1:0];
            end
        end
    end

    // Single-entry result buffer and issue-order tag counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_gcd_q   <= {WIDTH{1'b0}};
            res_tag_q   <= {TAG_W{1'b0}};
            tag_q       <= {TAG_W{1'b0}};
        end else if (capture_s) begin
            res_valid_q <= 1'b1;
            res_gcd_q   <= core_gcd;
            res_tag_q   <= tag_q;
            tag_q       <= tag_q + TAG_W'(1);
        end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Self-checking bench for gcd_job_scheduler with a behavioural GCD core beside it
// and a queue-based scoreboard of expected (gcd, tag) results in push order.
module tb_gcd_job_scheduler;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = 16'd0;
    logic [WIDTH-1:0] in_b = 16'd0;
    logic             core_start;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_done;
    logic [WIDTH-1:0] core_gcd;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_gcd;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    int tests_run = 0;
    int fails = 0;

    logic [WIDTH-1:0] exp_gcd_q [$];
    logic [TAG_W-1:0] exp_tag_q [$];
    int               tag_ctr;
    int               results_seen;
    bit               rand_ready;
    bit               hold_pending;
    bit               expect_low;
    logic [WIDTH-1:0] held_gcd;
    logic [TAG_W-1:0] held_tag;
    logic [WIDTH-1:0] last_gcd;
    logic [TAG_W-1:0] last_tag;

    gcd_job_scheduler #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_done  (core_done),
        .core_gcd   (core_gcd),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_gcd    (res_gcd),
        .res_tag    (res_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Core stand-in: subtractive GCD, done held for exactly two cycles
    function automatic logic [WIDTH-1:0] core_gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        x = a;
        y = b;
        while (x != 16'd0 && y != 16'd0) begin
            if (x > y) x = x - y;
            else y = y - x;
        end
        return x | y;
    endfunction

    // Reference: Euclid by remainder, gcd(0,x)=x
    function automatic logic [WIDTH-1:0] ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 16'(x);
    endfunction

    int               core_phase;
    int               core_wait;
    logic [WIDTH-1:0] core_res;
    logic             proto_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_phase <= 0;
            core_wait  <= 0;
            core_done  <= 1'b0;
            core_gcd   <= 16'd0;
            core_res   <= 16'd0;
            proto_err  <= 1'b0;
        end else begin
            case (core_phase)
                0: begin
                    if (core_start) begin
                        core_res   <= core_gcd_f(core_a, core_b);
                        core_wait  <= int'($urandom_range(1, 5));
                        core_phase <= 1;
                    end
                end
                1: begin
                    if (core_start) proto_err <= 1'b1;
                    if (core_wait == 0) begin
                        core_done  <= 1'b1;
                        core_gcd   <= core_res;
                        core_phase <= 2;
                    end else begin
                        core_wait <= core_wait - 1;
                    end
                end
                2: begin
                    if (core_start) proto_err <= 1'b1;
                    core_phase <= 3;
                end
                default: begin
                    if (core_start) proto_err <= 1'b1;
                    core_done  <= 1'b0;
                    core_gcd   <= ~core_res;
                    core_phase <= 0;
                end
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample handshakes with current values, then advance to the next negedge
    task automatic tick();
        logic [WIDTH-1:0] eg;
        logic [TAG_W-1:0] et;
        if (rst_n) begin
            if (expect_low) begin
                tests_run++;
                if (res_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL res_pulse: res_valid=%b, required 0 after acceptance", res_valid);
                end
                expect_low = 1'b0;
            end
            if (hold_pending) begin
                tests_run++;
                if (res_valid !== 1'b1 || res_gcd !== held_gcd || res_tag !== held_tag) begin
                    fails++;
                    $display("FAIL res_hold: valid=%b gcd=%0d tag=%0d, required 1/%0d/%0d",
                             res_valid, res_gcd, res_tag, held_gcd, held_tag);
                end
                hold_pending = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_gcd_q.push_back(ref_gcd(in_a, in_b));
                exp_tag_q.push_back(TAG_W'(tag_ctr % (1 << TAG_W)));
                tag_ctr++;
            end
            if (res_valid) begin
                if (res_ready) begin
                    tests_run++;
                    if (exp_gcd_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_result: got gcd=%0d tag=%0d, required no result", res_gcd, res_tag);
                    end else begin
                        eg = exp_gcd_q.pop_front();
                        et = exp_tag_q.pop_front();
                        if (res_gcd !== eg || res_tag !== et) begin
                            fails++;
                            $display("FAIL result: gcd=%0d tag=%0d, required gcd=%0d tag=%0d", res_gcd, res_tag, eg, et);
                        end
                    end
                    results_seen++;
                    last_gcd   = res_gcd;
                    last_tag   = res_tag;
                    expect_low = 1'b1;
                end else begin
                    hold_pending = 1'b1;
                    held_gcd     = res_gcd;
                    held_tag     = res_tag;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        if (!ok) begin
            tests_run++;
            fails++;
            $display("FAIL push_timeout: in_ready=%b, required 1 within 300 cycles", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n_expected);
        for (int i = 0; i < 3000 && (exp_gcd_q.size() != 0 || busy !== 1'b0); i++) tick();
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (exp_gcd_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drain: pending=%0d busy=%b, required 0/0", exp_gcd_q.size(), busy);
        end
        tests_run++;
        if (results_seen != n_expected) begin
            fails++;
            $display("FAIL result_count: %0d, required %0d", results_seen, n_expected);
        end
        tests_run++;
        if (proto_err !== 1'b0) begin
            fails++;
            $display("FAIL core_protocol: start while core active=%b, required 0", proto_err);
        end
    endtask

    task automatic apply_reset();
        in_valid   = 1'b0;
        res_ready  = 1'b0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_gcd_q.delete();
        exp_tag_q.delete();
        tag_ctr      = 0;
        results_seen = 0;
        hold_pending = 1'b0;
        expect_low   = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({in_ready, core_start, core_a, core_b, res_valid, res_gcd, res_tag, busy} !==
            {1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: rdy=%b st=%b a=%0d b=%0d v=%b g=%0d t=%0d busy=%b, required 1 0 0 0 0 0 0 0",
                     in_ready, core_start, core_a, core_b, res_valid, res_gcd, res_tag, busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        res_ready = 1'b1;
        push(16'd48, 16'd18);
        wait_drain(1);
        tests_run++;
        if (last_gcd !== 16'd6 || last_tag !== 4'd0) begin
            fails++;
            $display("FAIL single: gcd=%0d tag=%0d, required 6/0", last_gcd, last_tag);
        end
    endtask

    task automatic test_zero_operands();
        apply_reset();
        res_ready = 1'b1;
        push(16'd0, 16'd35);
        push(16'd27, 16'd0);
        push(16'd0, 16'd0);
        wait_drain(3);
        tests_run++;
        if (last_gcd !== 16'd0 || last_tag !== 4'd2) begin
            fails++;
            $display("FAIL zero_last: gcd=%0d tag=%0d, required 0/2", last_gcd, last_tag);
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int k = 1; k <= 5; k++) push(16'(k * 12), 16'(k * 18));
        in_valid = 1'b1;
        in_a     = 16'd91;
        in_b     = 16'd65;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL fifo_full: in_ready=%b, required 0 with %0d entries queued", in_ready, DEPTH);
            end
            tick();
        end
        res_ready = 1'b1;
        push(16'd91, 16'd65);
        wait_drain(6);
    endtask

    task automatic test_hold_result();
        apply_reset();
        push(16'd100, 16'd75);
        push(16'd64, 16'd48);
        for (int i = 0; i < 200 && res_valid !== 1'b1; i++) tick();
        tests_run++;
        if (res_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_wait: res_valid=%b, required 1", res_valid);
        end
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (core_start !== 1'b0 || res_valid !== 1'b1) begin
                fails++;
                $display("FAIL hold_no_issue: core_start=%b res_valid=%b, required 0/1", core_start, res_valid);
            end
            tick();
        end
        tests_run++;
        if (core_phase != 0) begin
            fails++;
            $display("FAIL hold_core_idle: core phase=%0d, required 0", core_phase);
        end
        res_ready = 1'b1;
        wait_drain(2);
        tests_run++;
        if (last_gcd !== 16'd16 || last_tag !== 4'd1) begin
            fail_note: begin end
            fails++;
            $display("FAIL hold_second: gcd=%0d tag=%0d, required 16/1", last_gcd, last_tag);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        res_ready = 1'b1;
        for (int k = 1; k <= 4; k++) push(16'(k * 300), 16'(k * 45));
        for (int i = 0; i < 100 && core_phase != 1; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, core_start, core_a, core_b, res_valid, res_gcd, res_tag, busy} !==
            {1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: rdy=%b st=%b a=%0d b=%0d v=%b g=%0d t=%0d busy=%b, required 1 0 0 0 0 0 0 0",
                     in_ready, core_start, core_a, core_b, res_valid, res_gcd, res_tag, busy);
        end
        exp_gcd_q.delete();
        exp_tag_q.delete();
        tag_ctr      = 0;
        results_seen = 0;
        hold_pending = 1'b0;
        expect_low   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tests_run++;
            if (res_valid !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle: res_valid=%b core_start=%b busy=%b, required 0/0/0",
                         res_valid, core_start, busy);
            end
            tick();
        end
    endtask

    task automatic test_tag_wrap();
        apply_reset();
        res_ready = 1'b1;
        for (int k = 1; k <= 17; k++) push(16'(k * 7), 16'd7);
        wait_drain(17);
        tests_run++;
        if (last_gcd !== 16'd7 || last_tag !== 4'd0) begin
            fails++;
            $display("FAIL tag_wrap: gcd=%0d tag=%0d, required 7/0", last_gcd, last_tag);
        end
    endtask

    task automatic test_random();
        apply_reset();
        rand_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            push(16'($urandom_range(0, 4095)), 16'($urandom_range(0, 4095)));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end
        rand_ready = 1'b0;
        res_ready  = 1'b1;
        wait_drain(30);
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_operands();
        test_fifo_full();
        test_hold_result();
        test_async_reset();
        test_tag_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
